// File: rtl/ofs_plat_avalon_mem_rdwr_skid_pipe.sv
// Avalon read/write request skid buffers with a fixed-latency response pipe,
// plus quiesce/drain control that reports when all traffic has left the block.

module ofs_plat_avalon_mem_rdwr_skid_chan #(
    parameter int N_BITS = 64,
    parameter int DEPTH  = 2,
    parameter int CW     = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              quiesce_q,
    input  logic              src_valid,
    input  logic [N_BITS-1:0] src_data,
    output logic              src_waitrequest,
    output logic              snk_valid,
    output logic [N_BITS-1:0] snk_data,
    input  logic              snk_waitrequest,
    output logic [CW-1:0]     count
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign snk_valid       = src_valid & ~quiesce_q & ~reset;
            assign snk_data        = src_data;
            assign src_waitrequest = snk_waitrequest | quiesce_q | reset;
            assign count           = {CW{1'b0}};
        end else begin : g_fifo
            localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
            localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
            localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

            logic [N_BITS-1:0] mem_r [DEPTH];
            logic [PW-1:0]     wr_ptr_r;
            logic [PW-1:0]     rd_ptr_r;
            logic [CW-1:0]     count_r;
            logic              push_s;
            logic              pop_s;

            // Pointers wrap at DEPTH-1 so non-power-of-2 depths work.
            function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
                if (ptr == LAST_PTR) begin
                    ptr_inc = {PW{1'b0}};
                end else begin
                    ptr_inc = ptr + PW'(1);
                end
            endfunction

            // Waitrequest depends only on registers so sink backpressure never
            // reaches the source combinationally; a full buffer refuses a push
            // even when it pops in the same cycle.
            assign src_waitrequest = reset | quiesce_q | (count_r == FULL_CNT);
            assign push_s          = src_valid & ~src_waitrequest;
            assign pop_s           = (count_r != {CW{1'b0}}) & ~snk_waitrequest;
            assign snk_valid       = (count_r != {CW{1'b0}});
            assign snk_data        = mem_r[rd_ptr_r];
            assign count           = count_r;

            // Occupancy and pointer state.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_r <= {PW{1'b0}};
                    rd_ptr_r <= {PW{1'b0}};
                    count_r  <= {CW{1'b0}};
                end else begin
                    if (push_s) begin
                        wr_ptr_r <= ptr_inc(wr_ptr_r);
                    end
                    if (pop_s) begin
                        rd_ptr_r <= ptr_inc(rd_ptr_r);
                    end
                    case ({push_s, pop_s})
                        2'b10:   count_r <= count_r + CW'(1);
                        2'b01:   count_r <= count_r - CW'(1);
                        default: count_r <= count_r;
                    endcase
                end
            end

            // Payload storage; contents are meaningless until counted valid.
            always_ff @(posedge clk) begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= src_data;
                end
            end
        end
    endgenerate
endmodule

module ofs_plat_avalon_mem_rdwr_skid_pipe #(
    parameter int N_RD_BITS  = 64,
    parameter int N_WR_BITS  = 640,
    parameter int N_RSP_BITS = 520,
    parameter int RD_DEPTH   = 2,
    parameter int WR_DEPTH   = 2,
    parameter int RSP_STAGES = 1,
    localparam int RD_CW = (RD_DEPTH == 0) ? 1 : $clog2(RD_DEPTH + 1),
    localparam int WR_CW = (WR_DEPTH == 0) ? 1 : $clog2(WR_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  quiesce,
    output logic                  idle,

    input  logic                  src_rd_read,
    input  logic [N_RD_BITS-1:0]  src_rd_data,
    output logic                  src_rd_waitrequest,
    output logic                  snk_rd_read,
    output logic [N_RD_BITS-1:0]  snk_rd_data,
    input  logic                  snk_rd_waitrequest,

    input  logic                  src_wr_write,
    input  logic [N_WR_BITS-1:0]  src_wr_data,
    output logic                  src_wr_waitrequest,
    output logic                  snk_wr_write,
    output logic [N_WR_BITS-1:0]  snk_wr_data,
    input  logic                  snk_wr_waitrequest,

    input  logic [1:0]            snk_rsp_valid,
    input  logic [N_RSP_BITS-1:0] snk_rsp_data,
    output logic [1:0]            src_rsp_valid,
    output logic [N_RSP_BITS-1:0] src_rsp_data,

    output logic [RD_CW-1:0]      rd_count,
    output logic [WR_CW-1:0]      wr_count
);
    logic quiesce_q;
    logic rsp_busy_s;

    // Quiesce is sampled once; everything downstream uses the registered copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quiesce_q <= 1'b0;
        end else begin
            quiesce_q <= quiesce;
        end
    end

    ofs_plat_avalon_mem_rdwr_skid_chan #(
        .N_BITS (N_RD_BITS),
        .DEPTH  (RD_DEPTH),
        .CW     (RD_CW)
    ) rd_chan (
        .clk             (clk),
        .reset           (reset),
        .quiesce_q       (quiesce_q),
        .src_valid       (src_rd_read),
        .src_data        (src_rd_data),
        .src_waitrequest (src_rd_waitrequest),
        .snk_valid       (snk_rd_read),
        .snk_data        (snk_rd_data),
        .snk_waitrequest (snk_rd_waitrequest),
        .count           (rd_count)
    );

    ofs_plat_avalon_mem_rdwr_skid_chan #(
        .N_BITS (N_WR_BITS),
        .DEPTH  (WR_DEPTH),
        .CW     (WR_CW)
    ) wr_chan (
        .clk             (clk),
        .reset           (reset),
        .quiesce_q       (quiesce_q),
        .src_valid       (src_wr_write),
        .src_data        (src_wr_data),
        .src_waitrequest (src_wr_waitrequest),
        .snk_valid       (snk_wr_write),
        .snk_data        (snk_wr_data),
        .snk_waitrequest (snk_wr_waitrequest),
        .count           (wr_count)
    );

    generate
        if (RSP_STAGES == 0) begin : g_rsp_comb
            assign src_rsp_valid = reset ? 2'b00 : snk_rsp_valid;
            assign src_rsp_data  = snk_rsp_data;
            assign rsp_busy_s    = 1'b0;
        end else begin : g_rsp_pipe
            logic [1:0]            valid_r [RSP_STAGES];
            logic [N_RSP_BITS-1:0] data_r  [RSP_STAGES];
            logic [RSP_STAGES-1:0] busy_s;

            // Response valid shift register; no flow control, so beats never merge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < RSP_STAGES; s++) begin
                        valid_r[s] <= 2'b00;
                    end
                end else begin
                    valid_r[0] <= snk_rsp_valid;
                    for (int s = 1; s < RSP_STAGES; s++) begin
                        valid_r[s] <= valid_r[s-1];
                    end
                end
            end

            // Response payload shift register, aligned with the valid bits.
            always_ff @(posedge clk) begin
                data_r[0] <= snk_rsp_data;
                for (int s = 1; s < RSP_STAGES; s++) begin
                    data_r[s] <= data_r[s-1];
                end
            end

            for (genvar s = 0; s < RSP_STAGES; s++) begin : g_busy
                assign busy_s[s] = |valid_r[s];
            end

            assign rsp_busy_s    = |busy_s;
            assign src_rsp_valid = valid_r[RSP_STAGES-1];
            assign src_rsp_data  = data_r[RSP_STAGES-1];
        end
    endgenerate

    assign idle = quiesce_q & (rd_count == {RD_CW{1'b0}}) &
                  (wr_count == {WR_CW{1'b0}}) & ~rsp_busy_s;
endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_skid_pipe.sv
// Scoreboard bench: instance A (rd D=2, wr D=4, 3 response stages) and
// instance B (rd D=3, wr D=0, combinational responses).

module tb_ofs_plat_avalon_mem_rdwr_skid_pipe;
    typedef struct { logic [15:0] data; int cyc; } item_t;
    typedef struct { logic [1:0] v; logic [15:0] data; int cyc; } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic a_quiesce, a_idle;
    logic a_src_rd_read, a_src_rd_waitrequest, a_snk_rd_read, a_snk_rd_waitrequest;
    logic [15:0] a_src_rd_data, a_snk_rd_data;
    logic a_src_wr_write, a_src_wr_waitrequest, a_snk_wr_write, a_snk_wr_waitrequest;
    logic [15:0] a_src_wr_data, a_snk_wr_data;
    logic [1:0] a_snk_rsp_valid, a_src_rsp_valid;
    logic [15:0] a_snk_rsp_data, a_src_rsp_data;
    logic [1:0] a_rd_count;
    logic [2:0] a_wr_count;

    logic b_quiesce, b_idle;
    logic b_src_rd_read, b_src_rd_waitrequest, b_snk_rd_read, b_snk_rd_waitrequest;
    logic [15:0] b_src_rd_data, b_snk_rd_data;
    logic b_src_wr_write, b_src_wr_waitrequest, b_snk_wr_write, b_snk_wr_waitrequest;
    logic [15:0] b_src_wr_data, b_snk_wr_data;
    logic [1:0] b_snk_rsp_valid, b_src_rsp_valid;
    logic [15:0] b_snk_rsp_data, b_src_rsp_data;
    logic [1:0] b_rd_count;
    logic [0:0] b_wr_count;

    item_t q_ard[$], q_awr[$], q_brd[$];
    rsp_t  q_arsp[$];
    bit    lat_ard = 1'b0;
    bit    b_stall_en = 1'b0;
    int    a_rd_max = 0, b_rd_max = 0, b_rd_got = 0;

    ofs_plat_avalon_mem_rdwr_skid_pipe #(
        .N_RD_BITS(16), .N_WR_BITS(16), .N_RSP_BITS(16),
        .RD_DEPTH(2), .WR_DEPTH(4), .RSP_STAGES(3)
    ) dut_a (
        .clk(clk), .reset(reset), .quiesce(a_quiesce), .idle(a_idle),
        .src_rd_read(a_src_rd_read), .src_rd_data(a_src_rd_data),
        .src_rd_waitrequest(a_src_rd_waitrequest),
        .snk_rd_read(a_snk_rd_read), .snk_rd_data(a_snk_rd_data),
        .snk_rd_waitrequest(a_snk_rd_waitrequest),
        .src_wr_write(a_src_wr_write), .src_wr_data(a_src_wr_data),
        .src_wr_waitrequest(a_src_wr_waitrequest),
        .snk_wr_write(a_snk_wr_write), .snk_wr_data(a_snk_wr_data),
        .snk_wr_waitrequest(a_snk_wr_waitrequest),
        .snk_rsp_valid(a_snk_rsp_valid), .snk_rsp_data(a_snk_rsp_data),
        .src_rsp_valid(a_src_rsp_valid), .src_rsp_data(a_src_rsp_data),
        .rd_count(a_rd_count), .wr_count(a_wr_count)
    );

    ofs_plat_avalon_mem_rdwr_skid_pipe #(
        .N_RD_BITS(16), .N_WR_BITS(16), .N_RSP_BITS(16),
        .RD_DEPTH(3), .WR_DEPTH(0), .RSP_STAGES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .quiesce(b_quiesce), .idle(b_idle),
        .src_rd_read(b_src_rd_read), .src_rd_data(b_src_rd_data),
        .src_rd_waitrequest(b_src_rd_waitrequest),
        .snk_rd_read(b_snk_rd_read), .snk_rd_data(b_snk_rd_data),
        .snk_rd_waitrequest(b_snk_rd_waitrequest),
        .src_wr_write(b_src_wr_write), .src_wr_data(b_src_wr_data),
        .src_wr_waitrequest(b_src_wr_waitrequest),
        .snk_wr_write(b_snk_wr_write), .snk_wr_data(b_snk_wr_data),
        .snk_wr_waitrequest(b_snk_wr_waitrequest),
        .snk_rsp_valid(b_snk_rsp_valid), .snk_rsp_data(b_snk_rsp_data),
        .src_rsp_valid(b_src_rsp_valid), .src_rsp_data(b_src_rsp_data),
        .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int ch, input logic v, input logic [15:0] d);
        case (ch)
            0:       begin a_src_rd_read  = v; a_src_rd_data = d; end
            1:       begin a_src_wr_write = v; a_src_wr_data = d; end
            default: begin b_src_rd_read  = v; b_src_rd_data = d; end
        endcase
    endtask

    function automatic logic src_wait(input int ch);
        case (ch)
            0:       return a_src_rd_waitrequest;
            1:       return a_src_wr_waitrequest;
            default: return b_src_rd_waitrequest;
        endcase
    endfunction

    // Hold a request until the source handshake completes, then expect it at the sink.
    task automatic src_push(input int ch, input logic [15:0] d);
        item_t it;
        int    n = 0;
        bit    done = 1'b0;
        set_src(ch, 1'b1, d);
        while (!done) begin
            @(negedge clk);
            if (!src_wait(ch)) begin
                it.data = d;
                it.cyc  = cyc;
                case (ch)
                    0:       q_ard.push_back(it);
                    1:       q_awr.push_back(it);
                    default: q_brd.push_back(it);
                endcase
                done = 1'b1;
            end else if (++n > 200) begin
                fail_now("src_push_timeout", d);
                done = 1'b1;
            end
            tick();
        end
        set_src(ch, 1'b0, d);
    endtask

    // Sink-side monitors pop the scoreboards.
    always @(negedge clk) begin
        item_t it;
        rsp_t  r;
        if (a_rd_count > a_rd_max) a_rd_max <= a_rd_count;
        if (b_rd_count > b_rd_max) b_rd_max <= b_rd_count;
        if (a_snk_rd_read && !a_snk_rd_waitrequest) begin
            if (q_ard.size() == 0) fail_now("ard_unexpected", a_snk_rd_data);
            else begin
                it = q_ard.pop_front();
                check("ard_data", a_snk_rd_data, it.data);
                if (lat_ard) check("ard_latency", cyc - it.cyc, 1);
            end
        end
        if (a_snk_wr_write && !a_snk_wr_waitrequest) begin
            if (q_awr.size() == 0) fail_now("awr_unexpected", a_snk_wr_data);
            else begin
                it = q_awr.pop_front();
                check("awr_data", a_snk_wr_data, it.data);
            end
        end
        if (b_snk_rd_read && !b_snk_rd_waitrequest) begin
            b_rd_got <= b_rd_got + 1;
            if (q_brd.size() == 0) fail_now("brd_unexpected", b_snk_rd_data);
            else begin
                it = q_brd.pop_front();
                check("brd_data", b_snk_rd_data, it.data);
            end
        end
        if (a_src_rsp_valid != 2'b00) begin
            if (q_arsp.size() == 0) fail_now("arsp_unexpected", {14'h0, a_src_rsp_valid});
            else begin
                r = q_arsp.pop_front();
                check("arsp_valid", a_src_rsp_valid, r.v);
                check("arsp_data", a_src_rsp_data, r.data);
                check("arsp_cycle", cyc, r.cyc);
            end
        end
    end

    // Random sink stall for the depth-3 wrap test.
    initial begin
        b_snk_rd_waitrequest = 1'b0;
        forever begin
            tick();
            b_snk_rd_waitrequest = b_stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    task automatic push_arsp(input logic [1:0] v, input logic [15:0] d);
        rsp_t r;
        r.v = v; r.data = d; r.cyc = cyc + 3;
        q_arsp.push_back(r);
    endtask

    initial begin
        int acc;
        reset = 1'b1;
        a_quiesce = 1'b0; b_quiesce = 1'b0;
        a_src_rd_read = 1'b0; a_src_rd_data = 16'h0; a_snk_rd_waitrequest = 1'b0;
        a_src_wr_write = 1'b0; a_src_wr_data = 16'h0; a_snk_wr_waitrequest = 1'b0;
        a_snk_rsp_valid = 2'b00; a_snk_rsp_data = 16'h0;
        b_src_rd_read = 1'b0; b_src_rd_data = 16'h0;
        b_src_wr_write = 1'b1; b_src_wr_data = 16'h0; b_snk_wr_waitrequest = 1'b0;
        b_snk_rsp_valid = 2'b11; b_snk_rsp_data = 16'hBEEF;

        // Reset state.
        @(negedge clk);
        check("rst_a_rd_wait", a_src_rd_waitrequest, 1);
        check("rst_a_wr_wait", a_src_wr_waitrequest, 1);
        check("rst_a_snk_rd", a_snk_rd_read, 0);
        check("rst_a_rsp_valid", a_src_rsp_valid, 0);
        check("rst_a_idle", a_idle, 0);
        check("rst_a_counts", {a_rd_count, a_wr_count}, 0);
        check("rst_b_snk_wr", b_snk_wr_write, 0);
        check("rst_b_wr_wait", b_src_wr_waitrequest, 1);
        check("rst_b_rsp_valid", b_src_rsp_valid, 0);
        tick();
        reset = 1'b0;
        b_src_wr_write = 1'b0; b_snk_rsp_valid = 2'b00;
        @(negedge clk);
        check("post_rst_a_rd_wait", a_src_rd_waitrequest, 0);
        tick();

        // D=2 streaming: 0..7 back-to-back, 1-cycle latency.
        lat_ard = 1'b1;
        for (int i = 0; i < 8; i++) src_push(0, 16'(i));
        repeat (3) tick();
        lat_ard = 1'b0;
        check("ard_stream_max_count", a_rd_max, 1);
        check("ard_stream_count", a_rd_count, 0);
        check("ard_stream_drained", q_ard.size(), 0);

        // D=4 fill with stalled sink, pop-at-full, refill.
        a_snk_wr_waitrequest = 1'b1;
        a_src_wr_write = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            a_src_wr_data = 16'h10 + 16'(acc);
            @(negedge clk);
            if (!a_src_wr_waitrequest) begin
                q_awr.push_back('{a_src_wr_data, cyc});
                acc++;
            end
            tick();
        end
        @(negedge clk);
        check("awr_accepted", acc, 4);
        check("awr_full_count", a_wr_count, 4);
        check("awr_full_wait", a_src_wr_waitrequest, 1);
        tick();
        a_snk_wr_waitrequest = 1'b0;
        @(negedge clk);
        check("awr_pop_at_full_wait", a_src_wr_waitrequest, 1);
        tick();
        @(negedge clk);
        check("awr_after_pop_count", a_wr_count, 3);
        check("awr_after_pop_wait", a_src_wr_waitrequest, 0);
        if (!a_src_wr_waitrequest) begin q_awr.push_back('{a_src_wr_data, cyc}); acc++; end
        tick();
        a_snk_wr_waitrequest = 1'b1;
        a_src_wr_data = 16'h15;
        @(negedge clk);
        check("awr_steady_count", a_wr_count, 3);
        if (!a_src_wr_waitrequest) begin q_awr.push_back('{a_src_wr_data, cyc}); acc++; end
        tick();
        a_src_wr_write = 1'b0;
        @(negedge clk);
        check("awr_refill_count", a_wr_count, 4);
        check("awr_refill_wait", a_src_wr_waitrequest, 1);
        tick();
        a_snk_wr_waitrequest = 1'b0;
        repeat (6) tick();
        check("awr_total_accepted", acc, 6);
        check("awr_drained", q_awr.size(), 0);

        // D=3 wrap under random sink stalls.
        b_stall_en = 1'b1;
        for (int i = 0; i < 20; i++) src_push(2, 16'h40 + 16'(i));
        for (int n = 0; n < 200 && q_brd.size() != 0; n++) tick();
        b_stall_en = 1'b0;
        tick();
        check("brd_drained", q_brd.size(), 0);
        check("brd_delivered", b_rd_got, 20);
        check("brd_max_le3", b_rd_max <= 3, 1);

        // D=0 wire-through and combinational responses.
        b_src_wr_write = 1'b1; b_src_wr_data = 16'hA5C3;
        @(negedge clk);
        check("bwr_pass_valid", b_snk_wr_write, 1);
        check("bwr_pass_data", b_snk_wr_data, 16'hA5C3);
        check("bwr_pass_wait", b_src_wr_waitrequest, 0);
        tick();
        b_snk_wr_waitrequest = 1'b1; b_src_wr_data = 16'h5A3C;
        @(negedge clk);
        check("bwr_mirror_wait", b_src_wr_waitrequest, 1);
        check("bwr_stall_data", b_snk_wr_data, 16'h5A3C);
        tick();
        b_snk_wr_waitrequest = 1'b0; b_quiesce = 1'b1;
        tick();
        @(negedge clk);
        check("bwr_quiesce_valid", b_snk_wr_write, 0);
        check("bwr_quiesce_wait", b_src_wr_waitrequest, 1);
        check("b_idle", b_idle, 1);
        tick();
        b_quiesce = 1'b0; b_src_wr_write = 1'b0;
        b_snk_rsp_valid = 2'b10; b_snk_rsp_data = 16'h1234;
        @(negedge clk);
        check("brsp_valid_wr", b_src_rsp_valid, 2'b10);
        check("brsp_data_wr", b_src_rsp_data, 16'h1234);
        tick();
        b_snk_rsp_valid = 2'b01; b_snk_rsp_data = 16'h4321;
        @(negedge clk);
        check("brsp_valid_rd", b_src_rsp_valid, 2'b01);
        check("brsp_data_rd", b_src_rsp_data, 16'h4321);
        tick();
        b_snk_rsp_valid = 2'b00;

        // Three response stages: beats emerge 3 cycles later, unmerged.
        a_snk_rsp_valid = 2'b01; a_snk_rsp_data = 16'hAAAA;
        @(negedge clk); push_arsp(2'b01, 16'hAAAA);
        tick();
        a_snk_rsp_valid = 2'b10; a_snk_rsp_data = 16'hBBBB;
        @(negedge clk); push_arsp(2'b10, 16'hBBBB);
        tick();
        a_snk_rsp_valid = 2'b00;
        repeat (6) tick();
        check("arsp_drained", q_arsp.size(), 0);

        // Quiesce with two buffered writes and a response in flight.
        a_snk_wr_waitrequest = 1'b1;
        src_push(1, 16'h21);
        src_push(1, 16'h22);
        a_quiesce = 1'b1;
        @(negedge clk);
        check("q_wait_before", a_src_wr_waitrequest, 0);
        check("q_idle_before", a_idle, 0);
        tick();
        a_snk_wr_waitrequest = 1'b0;
        a_snk_rsp_valid = 2'b11; a_snk_rsp_data = 16'h7777;
        @(negedge clk);
        push_arsp(2'b11, 16'h7777);
        check("q_wait_after", a_src_wr_waitrequest, 1);
        check("q_idle_c1", a_idle, 0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            a_snk_rsp_valid = 2'b00;
            @(negedge clk);
            check($sformatf("q_idle_c%0d", k), a_idle, (k == 5) ? 1 : 0);
        end
        check("q_drained", q_awr.size() + q_arsp.size(), 0);
        tick();
        a_quiesce = 1'b0;
        @(negedge clk);
        check("unq_idle_hold", a_idle, 1);
        tick();
        @(negedge clk);
        check("unq_idle_drop", a_idle, 0);
        check("unq_wait", a_src_wr_waitrequest, 0);
        tick();

        // Reset mid-burst discards buffered requests and in-flight responses.
        a_snk_rd_waitrequest = 1'b1;
        src_push(0, 16'h31);
        src_push(0, 16'h32);
        a_snk_rsp_valid = 2'b01; a_snk_rsp_data = 16'h9999;
        tick();
        a_snk_rsp_valid = 2'b00;
        reset = 1'b1;
        q_ard.delete();
        @(negedge clk);
        check("mid_rst_rd_wait", a_src_rd_waitrequest, 1);
        check("mid_rst_snk_rd", a_snk_rd_read, 0);
        check("mid_rst_rsp_valid", a_src_rsp_valid, 0);
        check("mid_rst_idle", a_idle, 0);
        check("mid_rst_count", a_rd_count, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rel_rd_wait", a_src_rd_waitrequest, 0);
        check("rel_rd_count", a_rd_count, 0);
        tick();
        a_snk_rd_waitrequest = 1'b0;
        src_push(0, 16'h33);
        repeat (4) tick();
        check("final_ard_drained", q_ard.size(), 0);
        check("final_arsp_drained", q_arsp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
